addsub_nibble_sequencer: RTL

// - Computes a WIDTH-bit add or subtract (a +/- b) by running one 4-bit add/sub slice

---
 rtl/addsub_nibble_sequencer_if.sv | 17 +
 rtl/addsub_nibble_sequencer.sv | 88 ++++++++
 2 files changed

// File: rtl/addsub_nibble_sequencer_if.sv
// addsub_nibble_sequencer_if: start/done handshake and operand/result bus for the nibble add/sub sequencer
//   master: drives start, op_sub, a, b; observes ready, busy, done, result, c_out, ovf
//   slave : the sequencer side of the same signals
interface addsub_nibble_sequencer_if #(parameter int WIDTH = 16);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;
    modport master (output start, op_sub, a, b, input ready, busy, done, result, c_out, ovf);
    modport slave  (input start, op_sub, a, b, output ready, busy, done, result, c_out, ovf);
endinterface

// File: rtl/addsub_nibble_sequencer.sv
// addsub_nibble_sequencer: WIDTH-bit a+/-b computed through one 4-bit slice, LS nibble first, one nibble per clock
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus.slave  start/op_sub/a/b in; ready/busy/done/result/c_out/ovf out
//   Optional macro ADDSUB_SEQ_OVF_DETECT_EN builds the signed-overflow tap; otherwise ovf is tied to 0.
module addsub_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input logic                       clk,
    input logic                       rst,
    addsub_nibble_sequencer_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic             sub_q, carry_q, c_out_q;
    logic [IW-1:0]    idx_q;
    logic             accept, last;
    logic [3:0]       a_n, b_n;
    logic [4:0]       sum;

    assign accept = (state_q == IDLE) && bus.start;
    assign last   = idx_q == IW'(NIB - 1);
    assign a_n    = a_q[{idx_q, 2'b00} +: 4];
    assign b_n    = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};
    assign sum    = {1'b0, a_n} + {1'b0, b_n} + {4'b0, carry_q};

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (accept) state_d = RUN;
        else if (state_q == RUN && last) state_d = DONE;
        else if (state_q == DONE) state_d = IDLE;
    end

    always_comb begin
        bus.ready = state_q == IDLE;
        bus.busy  = (state_q == RUN) || (state_q == DONE);
        bus.done  = state_q == DONE;
    end

    // carry_q is seeded with op_sub so the first nibble gets the +1 of two's-complement subtract
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
        end else if (accept) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            sub_q    <= bus.op_sub;
            carry_q  <= bus.op_sub;
            idx_q    <= '0;
            result_q <= '0;
        end else if (state_q == RUN) begin
            result_q[{idx_q, 2'b00} +: 4] <= sum[3:0];
            carry_q <= sum[4];
            idx_q   <= idx_q + 1'b1;
            if (last) c_out_q <= sum[4];
        end

    assign bus.result = result_q;
    assign bus.c_out  = c_out_q;

`ifdef ADDSUB_SEQ_OVF_DETECT_EN
    logic       ovf_q;
    logic [3:0] low;
    // low[3] is the carry into the MSB of the top nibble
    assign low = {1'b0, a_n[2:0]} + {1'b0, b_n[2:0]} + {3'b0, carry_q};
    always_ff @(posedge clk or posedge rst)
        if (rst) ovf_q <= 1'b0;
        else if (state_q == RUN && last) ovf_q <= low[3] ^ sum[4];
    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule
